aes128_stream_adapter: RTL and testbench

Word-stream front/back end for the AES-128 encryption core. Accepts 32-bit key and plaintext words over a valid/ready stream and assembles them into 128-bit key and data registers. It then pulses the core's start input, waits for end-of-encryption with a timeout, captures the ciphertext, and returns it as four 32-bit words on an output valid/ready stream. It sits directly upstream and downstream of the core: it drives the core's key/data/start inputs and consumes its end-of-encryption flag and output.

---
 rtl/aes128_stream_pkg.sv | 26 ++
 rtl/aes128_word_serializer.sv | 62 ++++++
 rtl/aes128_stream_adapter.sv | 169 ++++++++++++++++
 tb/tb_aes128_stream_adapter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_stream_pkg.sv
// Shared types and constants for the AES-128 word-stream adapter.
package aes128_stream_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int CNT_W           = 2;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
  localparam int TMO_W           = 6;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WORDS_PER_BLOCK - 2);

  // First word of a group ends up in the most significant slot.
  function automatic logic [BLOCK_W-1:0] shift_in(input logic [BLOCK_W-1:0] r,
                                                  input logic [WORD_W-1:0]  w);
    return {r[BLOCK_W-WORD_W-1:0], w};
  endfunction

endpackage

// File: rtl/aes128_word_serializer.sv
// Loads a 128-bit block and streams it out as four 32-bit words, MSW first,
// over valid/ready with a last flag on the final word.
module aes128_word_serializer
  import aes128_stream_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WORD_W-1:0]  out_word,
  output logic               out_last
);

  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               fire;

  assign fire = valid_q & out_ready;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = 2'd0;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (fire) begin
      shreg_d = {shreg_q[BLOCK_W-WORD_W-1:0], 32'd0};
      cnt_d   = cnt_q + 2'd1;
      valid_d = ~last_q;
      last_d  = (cnt_q == CNT_PENULT);
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q <= 128'd0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_word  = shreg_q[BLOCK_W-1 -: WORD_W];
  assign out_last  = last_q;

endmodule

// File: rtl/aes128_stream_adapter.sv
// Word-stream front/back end for the AES-128 core: assembles key and plaintext,
// starts the core, waits for done with a timeout and streams the ciphertext out.
module aes128_stream_adapter
  import aes128_stream_pkg::*;
#(
  parameter int CORE_TIMEOUT = 63
) (
  input  logic               pi_clk,
  input  logic               pi_rst,
  input  logic               pi_in_valid,
  input  logic [WORD_W-1:0]  pi_in_word,
  input  logic               pi_in_is_key,
  output logic               po_in_ready,
  output logic               po_out_valid,
  output logic [WORD_W-1:0]  po_out_word,
  output logic               po_out_last,
  input  logic               pi_out_ready,
  output logic [BLOCK_W-1:0] po_core_key,
  output logic [BLOCK_W-1:0] po_core_data,
  output logic               po_core_start,
  input  logic               pi_core_done,
  input  logic [BLOCK_W-1:0] pi_core_out,
  output logic               po_key_valid,
  output logic               po_err_nokey,
  output logic               po_err_timeout
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(CORE_TIMEOUT);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] key_q, key_d, data_q, data_d;
  logic [CNT_W-1:0]   key_cnt_q, key_cnt_d, data_cnt_q, data_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_next;
  logic               key_valid_q, key_valid_d;
  logic               err_nokey_q, err_nokey_d, err_timeout_q, err_timeout_d;
  logic               in_ready_q, in_ready_d, core_start_q, core_start_d;
  logic               in_fire, data_full, tmo_hit, ser_load, out_done;

  assign in_fire   = pi_in_valid & in_ready_q;
  assign data_full = in_fire & ~pi_in_is_key & key_valid_q & (data_cnt_q == CNT_LAST);
  assign tmo_next  = tmo_cnt_q + 6'd1;
  assign tmo_hit   = (tmo_next == TMO_LIMIT);
  assign out_done  = po_out_valid & pi_out_ready & po_out_last;

  // State register.
  always_ff @(posedge pi_clk) begin
    if (!pi_rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a done in the timeout cycle takes priority over the abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  state_d = data_full ? S_START : S_FILL;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (pi_core_done) begin
          state_d = S_DRAIN;
        end else if (tmo_hit) begin
          state_d = S_FILL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN: state_d = out_done ? S_FILL : S_DRAIN;
      default: state_d = S_FILL;
    endcase
  end

  // Registered outputs follow the next state so they line up with it.
  always_comb begin
    in_ready_d   = (state_d == S_FILL);
    core_start_d = (state_d == S_START);
  end

  // Word assembly, counters and sticky error flags.
  always_comb begin
    key_d         = key_q;
    data_d        = data_q;
    key_cnt_d     = key_cnt_q;
    data_cnt_d    = data_cnt_q;
    key_valid_d   = key_valid_q;
    err_nokey_d   = err_nokey_q;
    err_timeout_d = err_timeout_q;
    tmo_cnt_d     = tmo_cnt_q;
    ser_load      = 1'b0;
    case (state_q)
      S_FILL: begin
        if (in_fire && pi_in_is_key) begin
          key_d       = shift_in(key_q, pi_in_word);
          key_cnt_d   = key_cnt_q + 2'd1;
          key_valid_d = (key_cnt_q == CNT_LAST);
          data_cnt_d  = 2'd0;
        end else if (in_fire && key_valid_q) begin
          data_d     = shift_in(data_q, pi_in_word);
          data_cnt_d = data_cnt_q + 2'd1;
        end else if (in_fire) begin
          err_nokey_d = 1'b1;
        end else begin
          key_d = key_q;
        end
      end
      S_START: tmo_cnt_d = 6'd0;
      S_WAIT: begin
        if (pi_core_done) begin
          ser_load = 1'b1;
        end else if (tmo_hit) begin
          err_timeout_d = 1'b1;
          data_cnt_d    = 2'd0;
        end else begin
          tmo_cnt_d = tmo_next;
        end
      end
      S_DRAIN: data_cnt_d = out_done ? 2'd0 : data_cnt_q;
      default: tmo_cnt_d = 6'd0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge pi_clk) begin
    if (!pi_rst) begin
      key_q         <= 128'd0;
      data_q        <= 128'd0;
      key_cnt_q     <= 2'd0;
      data_cnt_q    <= 2'd0;
      key_valid_q   <= 1'b0;
      err_nokey_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      tmo_cnt_q     <= 6'd0;
      in_ready_q    <= 1'b0;
      core_start_q  <= 1'b0;
    end else begin
      key_q         <= key_d;
      data_q        <= data_d;
      key_cnt_q     <= key_cnt_d;
      data_cnt_q    <= data_cnt_d;
      key_valid_q   <= key_valid_d;
      err_nokey_q   <= err_nokey_d;
      err_timeout_q <= err_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
      in_ready_q    <= in_ready_d;
      core_start_q  <= core_start_d;
    end
  end

  aes128_word_serializer u_ser (
    .clk       (pi_clk),
    .rst_n     (pi_rst),
    .load      (ser_load),
    .load_data (pi_core_out),
    .out_ready (pi_out_ready),
    .out_valid (po_out_valid),
    .out_word  (po_out_word),
    .out_last  (po_out_last)
  );

  assign po_in_ready    = in_ready_q;
  assign po_core_key    = key_q;
  assign po_core_data   = data_q;
  assign po_core_start  = core_start_q;
  assign po_key_valid   = key_valid_q;
  assign po_err_nokey   = err_nokey_q;
  assign po_err_timeout = err_timeout_q;

endmodule

// File: tb/tb_aes128_stream_adapter.sv
// Directed + randomized bench for aes128_stream_adapter; the bench plays the AES core.
module tb_aes128_stream_adapter;

  localparam int TMO = 63;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] SP_PT    = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
  localparam logic [127:0] SP_CT    = 128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97;

  logic         pi_clk = 1'b0, pi_rst = 1'b0;
  logic         pi_in_valid = 1'b0, pi_in_is_key = 1'b0, pi_out_ready = 1'b0, pi_core_done = 1'b0;
  logic [31:0]  pi_in_word = 32'd0;
  logic [127:0] pi_core_out = 128'd0;
  logic         po_in_ready, po_out_valid, po_out_last, po_core_start;
  logic         po_key_valid, po_err_nokey, po_err_timeout;
  logic [31:0]  po_out_word;
  logic [127:0] po_core_key, po_core_data;

  int           total = 0, bad = 0;
  logic [127:0] model_key = 128'd0;

  aes128_stream_adapter #(.CORE_TIMEOUT(TMO)) dut (
    .pi_clk(pi_clk), .pi_rst(pi_rst),
    .pi_in_valid(pi_in_valid), .pi_in_word(pi_in_word), .pi_in_is_key(pi_in_is_key),
    .po_in_ready(po_in_ready),
    .po_out_valid(po_out_valid), .po_out_word(po_out_word), .po_out_last(po_out_last),
    .pi_out_ready(pi_out_ready),
    .po_core_key(po_core_key), .po_core_data(po_core_data), .po_core_start(po_core_start),
    .pi_core_done(pi_core_done), .pi_core_out(pi_core_out),
    .po_key_valid(po_key_valid), .po_err_nokey(po_err_nokey), .po_err_timeout(po_err_timeout)
  );

  always #5 pi_clk = ~pi_clk;

  // Stand-in AES core: real answers for the two published vectors, a fixed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
    if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    if (k == FIPS_KEY && d == SP_PT) return SP_CT;
    return k ^ {d[63:0], d[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, 128'({po_in_ready, po_out_valid, po_out_last, po_core_start,
                               po_key_valid, po_err_nokey, po_err_timeout}), 128'd0);
    check({tag, "_word"}, 128'(po_out_word), 128'd0);
    check({tag, "_key"}, po_core_key, 128'd0);
    check({tag, "_data"}, po_core_data, 128'd0);
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input logic [31:0] w, input logic is_key);
    int n = 0;
    pi_in_valid = 1'b1; pi_in_word = w; pi_in_is_key = is_key;
    while (!po_in_ready && n < 100) begin
      @(negedge pi_clk); n++;
    end
    check("in_ready_wait", 128'(po_in_ready), 128'd1);
    @(posedge pi_clk);
    @(negedge pi_clk);
    pi_in_valid = 1'b0;
  endtask

  task automatic send_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) begin
      send_word(k[127-32*i -: 32], 1'b1);
      if (i == 0) check("kv_clear_first", 128'(po_key_valid), 128'd0);
    end
    model_key = k;
    check("key_valid", 128'(po_key_valid), 128'd1);
    check("core_key_loaded", po_core_key, k);
  endtask

  // Sends four data words, checks the start pulse; returns in the first S_WAIT cycle.
  task automatic start_block(input logic [127:0] d);
    for (int i = 0; i < 4; i++) send_word(d[127-32*i -: 32], 1'b0);
    check("start_pulse", 128'(po_core_start), 128'd1);
    check("ready_low_start", 128'(po_in_ready), 128'd0);
    check("core_key", po_core_key, model_key);
    check("core_data", po_core_data, d);
    @(negedge pi_clk);
    check("start_one_cycle", 128'(po_core_start), 128'd0);
  endtask

  task automatic pulse_done();
    pi_core_done = 1'b1;
    pi_core_out  = core_fn(po_core_key, po_core_data);
    @(negedge pi_clk);
    pi_core_done = 1'b0;
    pi_core_out  = rand128();
  endtask

  task automatic drain(input logic [127:0] ct, input bit bp);
    int idx = 0, cyc = 0;
    logic stalled = 1'b0, r;
    logic [31:0] prevw = 32'd0, expw;
    while (idx < 4 && cyc < 200) begin
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      pi_out_ready = r;
      if (cyc == 0) check("first_valid", 128'(po_out_valid), 128'd1);
      if (stalled) begin
        check("hold_valid", 128'(po_out_valid), 128'd1);
        check("hold_word", 128'(po_out_word), 128'(prevw));
      end
      if (po_out_valid && r) begin
        expw = ct[127-32*idx -: 32];
        check("out_word", 128'(po_out_word), 128'(expw));
        check("out_last", 128'(po_out_last), 128'(idx == 3));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = po_out_valid;
        prevw   = po_out_word;
      end
      @(negedge pi_clk);
      cyc++;
    end
    pi_out_ready = 1'b0;
    check("drain_count", 128'(idx), 128'd4);
    if (!bp) check("drain_cycles", 128'(cyc), 128'd4);
    check("ready_after_drain", 128'(po_in_ready), 128'd1);
    check("valid_after_drain", 128'(po_out_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] k, d;
    int lat;

    // Reset state
    repeat (3) @(negedge pi_clk);
    check_reset("reset");
    pi_rst = 1'b1;
    @(negedge pi_clk);
    check("ready_after_reset", 128'(po_in_ready), 128'd1);

    // Data before any key
    send_word(32'h1111_1111, 1'b0);
    check("err_nokey", 128'(po_err_nokey), 128'd1);
    check("nokey_no_start", 128'({po_core_start, po_key_valid, po_in_ready}), 128'b001);

    // FIPS-197 vector, no back-pressure
    send_key(FIPS_KEY);
    start_block(FIPS_PT);
    repeat (5) @(negedge pi_clk);
    pulse_done();
    drain(FIPS_CT, 1'b0);

    // Second block with retained key, random back-pressure
    start_block(SP_PT);
    @(negedge pi_clk);
    pulse_done();
    drain(SP_CT, 1'b1);

    // Random keys/data; first pass also abandons a partial data group with a key reload
    for (int it = 0; it < 3; it++) begin
      k = rand128();
      if (it == 0) begin
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
      end
      send_key(k);
      d = rand128();
      start_block(d);
      lat = $urandom_range(0, 20);
      repeat (lat) @(negedge pi_clk);
      pulse_done();
      drain(core_fn(k, d), 1'b1);
    end

    // Done in the very cycle the timeout would fire: done wins
    d = rand128();
    start_block(d);
    repeat (TMO - 1) @(negedge pi_clk);
    pulse_done();
    check("done_wins_no_err", 128'(po_err_timeout), 128'd0);
    drain(core_fn(model_key, d), 1'b0);

    // Core never finishes
    start_block(rand128());
    repeat (TMO - 1) @(negedge pi_clk);
    check("tmo_not_early", 128'(po_err_timeout), 128'd0);
    @(negedge pi_clk);
    check("tmo_set", 128'(po_err_timeout), 128'd1);
    check("tmo_no_output", 128'(po_out_valid), 128'd0);
    @(negedge pi_clk);
    check("tmo_ready", 128'(po_in_ready), 128'd1);
    pulse_done();
    check("done_in_fill_ignored", 128'({po_out_valid, po_core_start}), 128'd0);

    // Normal block after a timeout
    d = rand128();
    start_block(d);
    repeat (3) @(negedge pi_clk);
    pulse_done();
    drain(core_fn(model_key, d), 1'b1);

    // Reset in S_WAIT, then a late done
    start_block(rand128());
    repeat (3) @(negedge pi_clk);
    pi_rst = 1'b0;
    @(negedge pi_clk);
    check_reset("rst_wait");
    pi_rst = 1'b1;
    pi_core_done = 1'b1;
    pi_core_out = rand128();
    repeat (2) @(negedge pi_clk);
    pi_core_done = 1'b0;
    check("late_done_ignored", 128'({po_out_valid, po_key_valid, po_in_ready}), 128'b001);
    @(negedge pi_clk);
    check("late_done_no_start", 128'({po_out_valid, po_core_start}), 128'd0);

    // Reset in S_DRAIN after one word
    send_key(FIPS_KEY);
    start_block(FIPS_PT);
    repeat (2) @(negedge pi_clk);
    pulse_done();
    pi_out_ready = 1'b1;
    check("drain_first_word", 128'(po_out_word), 128'h3925841d);
    @(negedge pi_clk);
    pi_rst = 1'b0;
    @(negedge pi_clk);
    check_reset("rst_drain");
    pi_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pi_clk);
      check("no_words_after_rst", 128'(po_out_valid), 128'd0);
    end
    pi_out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
